// File: rtl/lfsr_checker.sv
// Receive-side checker for the DDS noise LFSR: rebuilds the generator state from the word
// stream, then flywheels a local copy to flag mismatches, count errors and detect lock-up.
module lfsr_checker #(
    parameter int unsigned N           = 14,
    parameter int unsigned M           = 12,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [M-1:0]     in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             stuck
);

    localparam int unsigned K  = N - M;
    localparam int unsigned AW = $clog2(K + 1);
    localparam int unsigned MW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [0:0] {StAcq, StLock} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    acq_q, acq_d;
    logic [M-1:0]     prev_q, prev_d;
    logic [N-1:0]     pred_q, pred_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_pulse_q, err_pulse_d;
    logic             stuck_q, stuck_d;

    logic [N-1:0] asm_state, acq_state, pred_next;
    logic         shift_ok, acq_done, all_ones, mismatch, loss;

    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
        logic fb;
        fb = ~(s[N-1] ^ s[N-2] ^ s[N-3] ^ s[1]);
        return {s[N-2:0], fb};
    endfunction

    // During acquisition pred_q holds the partially assembled state of word 0.
    always_comb begin
        asm_state = pred_q;
        for (int i = 0; i < int'(K); i++) begin
            if (acq_q == AW'(int'(K) - i)) asm_state[i] = in_data[0];
        end
        acq_state = asm_state;
        for (int i = 0; i < int'(K); i++) acq_state = lfsr_step(acq_state);
    end

    assign shift_ok  = (in_data[M-1:1] == prev_q[M-2:0]);
    assign acq_done  = (acq_q == AW'(K));
    assign all_ones  = &asm_state;
    assign pred_next = lfsr_step(pred_q);
    assign mismatch  = (in_data != pred_next[N-1:K]);
    assign loss      = mismatch && (miss_q == MW'(LOSS_THRESH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StAcq;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            unique case (state_q)
                StAcq:  if (acq_q != '0 && shift_ok && acq_done && !all_ones) state_d = StLock;
                StLock: if (loss) state_d = StAcq;
                default: state_d = StAcq;
            endcase
        end
    end

    always_comb begin
        locked    = (state_q == StLock);
        err_pulse = err_pulse_q;
        err_count = err_cnt_q;
        stuck     = stuck_q;
    end

    always_comb begin
        acq_d       = acq_q;
        prev_d      = prev_q;
        pred_d      = pred_q;
        miss_d      = miss_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        stuck_d     = stuck_q;
        if (clear) begin
            err_cnt_d = '0;
            stuck_d   = 1'b0;
        end
        if (in_valid) begin
            if (state_q == StAcq) begin
                prev_d = in_data;
                if (acq_q == '0 || !shift_ok) begin
                    // Inconsistent word starts a fresh acquisition as word 0.
                    pred_d = {in_data, {K{1'b0}}};
                    acq_d  = AW'(1);
                end else if (!acq_done) begin
                    pred_d = asm_state;
                    acq_d  = acq_q + 1'b1;
                end else begin
                    acq_d  = '0;
                    miss_d = '0;
                    if (all_ones) stuck_d = 1'b1;
                    else          pred_d  = acq_state;
                end
            end else begin
                pred_d = pred_next;
                if (mismatch) begin
                    err_pulse_d = 1'b1;
                    if (!clear && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    miss_d = loss ? '0 : miss_q + 1'b1;
                    if (loss) acq_d = '0;
                end else begin
                    miss_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acq_q       <= '0;
            prev_q      <= '0;
            pred_q      <= '0;
            miss_q      <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            acq_q       <= acq_d;
            prev_q      <= prev_d;
            pred_q      <= pred_d;
            miss_q      <= miss_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            stuck_q     <= stuck_d;
        end
    end

endmodule
